// File: rtl/amstrad_crtc.sv
// UM6845R (type 1) CRTC: character-rate HSYNC/VSYNC/DE timing and MA/RA video address generation.
// Optional readback of R12-R17 and status via &BFxx is enabled with `define CRTC_READBACK_EN.
module amstrad_crtc (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE_1M,
  input  logic        WE,
  input  logic        RE,
  input  logic        A,
  input  logic [7:0]  D,
  output logic [7:0]  Q,
  output logic [13:0] MA,
  output logic [4:0]  RA,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE
);

  function automatic logic [7:0] reg_default(input int idx);
    case (idx)
      0:       return 8'd63;
      1:       return 8'd40;
      2:       return 8'd46;
      3:       return 8'h8E;
      4:       return 8'd38;
      6:       return 8'd25;
      7:       return 8'd30;
      9:       return 8'd7;
      12:      return 8'h30;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] reg_mask(input logic [4:0] idx);
    case (idx)
      5'd4, 5'd6, 5'd7: return 8'h7F;
      5'd5, 5'd9:       return 8'h1F;
      5'd12:            return 8'h3F;
      default:          return 8'hFF;
    endcase
  endfunction

  logic [4:0]  ar_q, ar_d;
  logic [7:0]  regs_q [0:17];
  logic [7:0]  regs_d [0:17];

  logic [7:0]  hcc_q, hcc_d;
  logic [4:0]  vlc_q, vlc_d;
  logic [6:0]  vcc_q, vcc_d;
  logic [4:0]  adj_q, adj_d;
  logic        in_adj_q, in_adj_d;
  logic [13:0] row_base_q, row_base_d;
  logic        sol_q, sol_d;
  logic        hsync_q, hsync_d;
  logic [3:0]  hsw_cnt_q, hsw_cnt_d;
  logic        vsync_q, vsync_d;
  logic [3:0]  vsw_cnt_q, vsw_cnt_d;
  logic        hdisp_q, hdisp_d;
  logic        vdisp_q, vdisp_d;
  logic [13:0] ma_q, ma_d;
  logic [4:0]  ra_q, ra_d;
  logic        de_q, de_d;
  logic [7:0]  q_q, q_d;

  logic [7:0]  htotal, hdisp_end, hsync_pos;
  logic [3:0]  hsw;
  logic [6:0]  vtotal, vdisp_end, vsync_pos;
  logic [4:0]  vadjust, max_ras;
  logic [13:0] start_addr;
  logic        eol, frame_end, vblank;
  logic        unused_bits;

  assign htotal     = regs_q[0];
  assign hdisp_end  = regs_q[1];
  assign hsync_pos  = regs_q[2];
  assign hsw        = regs_q[3][3:0];
  assign vtotal     = regs_q[4][6:0];
  assign vadjust    = regs_q[5][4:0];
  assign vdisp_end  = regs_q[6][6:0];
  assign vsync_pos  = regs_q[7][6:0];
  assign max_ras    = regs_q[9][4:0];
  assign start_addr = {regs_q[12][5:0], regs_q[13]};

  assign eol    = (hcc_q == htotal);
  assign vblank = in_adj_q || (vcc_q >= vdisp_end);

  // Stored-only registers and the read strobe in the write-only build are sunk here.
  always_comb begin
    unused_bits = RE ^ vblank;
    for (int i = 0; i < 18; i++) unused_bits = unused_bits ^ (^regs_q[i]);
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    regs_d = regs_q;
    ar_d   = ar_q;
    if (WE) begin
      if (!A)                 ar_d = D[4:0];
      else if (ar_q <= 5'd17) regs_d[ar_q] = D & reg_mask(ar_q);
    end
  end

  always_comb begin
    hcc_d      = hcc_q;
    vlc_d      = vlc_q;
    vcc_d      = vcc_q;
    adj_d      = adj_q;
    in_adj_d   = in_adj_q;
    row_base_d = row_base_q;
    sol_d      = sol_q;
    hsync_d    = hsync_q;
    hsw_cnt_d  = hsw_cnt_q;
    vsync_d    = vsync_q;
    vsw_cnt_d  = vsw_cnt_q;
    hdisp_d    = hdisp_q;
    vdisp_d    = vdisp_q;
    ma_d       = ma_q;
    ra_d       = ra_q;
    de_d       = de_q;
    frame_end  = 1'b0;

    if (CE_1M) begin
      hcc_d = eol ? 8'd0 : hcc_q + 8'd1;
      sol_d = eol;

      if (hsync_q) begin
        if ({1'b0, hsw_cnt_q} + 5'd1 >= {1'b0, hsw}) hsync_d = 1'b0;
        else                                         hsw_cnt_d = hsw_cnt_q + 4'd1;
      end else if (hcc_q == hsync_pos && hsw != 4'd0) begin
        hsync_d   = 1'b1;
        hsw_cnt_d = 4'd0;
      end

      if (hcc_q == hdisp_end) hdisp_d = 1'b0;
      else if (hcc_q == 8'd0) hdisp_d = 1'b1;

      // VSYNC width is counted in whole lines at each line's first character.
      if (sol_q) begin
        if (vsync_q) begin
          if (vsw_cnt_q == 4'd15) vsync_d = 1'b0;
          else                    vsw_cnt_d = vsw_cnt_q + 4'd1;
        end else if (!in_adj_q && vcc_q == vsync_pos && vlc_q == 5'd0) begin
          vsync_d   = 1'b1;
          vsw_cnt_d = 4'd0;
        end
      end

      if (eol) begin
        if (vlc_q == max_ras) row_base_d = row_base_q + {6'b0, hdisp_end};
        if (in_adj_q) begin
          if ({1'b0, adj_q} + 6'd1 >= {1'b0, vadjust}) frame_end = 1'b1;
          else                                         adj_d = adj_q + 5'd1;
        end else if (vlc_q != max_ras) begin
          vlc_d = vlc_q + 5'd1;
        end else if (vcc_q != vtotal) begin
          vlc_d = 5'd0;
          vcc_d = vcc_q + 7'd1;
          if (vcc_q + 7'd1 == vdisp_end) vdisp_d = 1'b0;
        end else if (vadjust != 5'd0) begin
          vlc_d    = 5'd0;
          in_adj_d = 1'b1;
          adj_d    = 5'd0;
        end else begin
          frame_end = 1'b1;
        end
        if (frame_end) begin
          vcc_d      = 7'd0;
          vlc_d      = 5'd0;
          in_adj_d   = 1'b0;
          adj_d      = 5'd0;
          row_base_d = start_addr;
          vdisp_d    = (vdisp_end != 7'd0);
        end
      end

      ma_d = row_base_q + {6'b0, hcc_q};
      ra_d = vlc_q;
      de_d = hdisp_d && vdisp_q && !in_adj_q && (vdisp_end != 7'd0);
    end
  end

  always_comb begin
    q_d = q_q;
`ifdef CRTC_READBACK_EN
    if (RE && A) begin
      if (ar_q >= 5'd12 && ar_q <= 5'd17) q_d = regs_q[ar_q];
      else if (ar_q == 5'd31)             q_d = {2'b00, vblank, 5'b00000};
      else                                q_d = 8'h00;
    end
`else
    q_d = 8'hFF;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the register file is reset too, since its defaults define the power-on video timing.
      for (int i = 0; i < 18; i++) regs_q[i] <= reg_default(i);
      ar_q       <= 5'd0;
      hcc_q      <= 8'd0;
      vlc_q      <= 5'd0;
      vcc_q      <= 7'd0;
      adj_q      <= 5'd0;
      in_adj_q   <= 1'b0;
      row_base_q <= 14'h3000;
      sol_q      <= 1'b1;
      hsync_q    <= 1'b0;
      hsw_cnt_q  <= 4'd0;
      vsync_q    <= 1'b0;
      vsw_cnt_q  <= 4'd0;
      hdisp_q    <= 1'b0;
      vdisp_q    <= 1'b1;
      ma_q       <= 14'h3000;
      ra_q       <= 5'd0;
      de_q       <= 1'b0;
      q_q        <= 8'hFF;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs_q     <= regs_d;
      ar_q       <= ar_d;
      hcc_q      <= hcc_d;
      vlc_q      <= vlc_d;
      vcc_q      <= vcc_d;
      adj_q      <= adj_d;
      in_adj_q   <= in_adj_d;
      row_base_q <= row_base_d;
      sol_q      <= sol_d;
      hsync_q    <= hsync_d;
      hsw_cnt_q  <= hsw_cnt_d;
      vsync_q    <= vsync_d;
      vsw_cnt_q  <= vsw_cnt_d;
      hdisp_q    <= hdisp_d;
      vdisp_q    <= vdisp_d;
      ma_q       <= ma_d;
      ra_q       <= ra_d;
      de_q       <= de_d;
      q_q        <= q_d;
    end
  end

  assign Q     = q_q;
  assign MA    = ma_q;
  assign RA    = ra_q;
  assign HSYNC = hsync_q;
  assign VSYNC = vsync_q;
  assign DE    = de_q;

endmodule

// File: tb/tb_amstrad_crtc.sv
// Directed bench for amstrad_crtc: default frame, HSW=0, vertical adjust, start address and stride,
// mid-frame reset and readback (expectation follows CRTC_READBACK_EN).
module tb_amstrad_crtc;

  logic        CLK = 1'b0;
  logic        RESET, CE_1M, WE, RE, A;
  logic [7:0]  D;
  logic [7:0]  Q;
  logic [13:0] MA;
  logic [4:0]  RA;
  logic        HSYNC, VSYNC, DE;

  amstrad_crtc dut (
    .CLK(CLK), .RESET(RESET), .CE_1M(CE_1M), .WE(WE), .RE(RE), .A(A), .D(D),
    .Q(Q), .MA(MA), .RA(RA), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected frame geometry of the frame being run, and CE index within it.
  int cur_k, g_base, g_hd, g_hsw, g_nonadj, g_vs0, g_de_lines;
  int err_hs, err_vs, err_de, err_ra, err_ma;
  logic [13:0] ma_l0, ma_l8;

`ifdef CRTC_READBACK_EN
  localparam logic [7:0] EXP_R12 = 8'h2A;
  localparam logic [7:0] EXP_ST  = 8'h20;
`else
  localparam logic [7:0] EXP_R12 = 8'hFF;
  localparam logic [7:0] EXP_ST  = 8'hFF;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_geom(input int base, input int hd, input int hsw, input int nonadj,
                          input int vs0, input int de_lines);
    g_base = base; g_hd = hd; g_hsw = hsw; g_nonadj = nonadj; g_vs0 = vs0; g_de_lines = de_lines;
    cur_k = 0;
    err_hs = 0; err_vs = 0; err_de = 0; err_ra = 0; err_ma = 0;
    ma_l0 = 14'h0; ma_l8 = 14'h0;
  endtask

  task automatic clk_step(input logic we, input logic a, input logic [7:0] d, input logic re);
    int line, h;
    logic exp_hs, exp_vs, exp_de;
    logic [4:0]  exp_ra;
    logic [13:0] exp_ma;
    WE = we; A = a; D = d; RE = re;
    @(negedge CLK);
    WE = 1'b0; A = 1'b0; D = 8'h00; RE = 1'b0;
    line   = cur_k / 64;
    h      = cur_k % 64;
    exp_hs = (g_hsw != 0) && (h >= 46) && (h < 46 + g_hsw);
    exp_vs = (g_vs0 >= 0) && (line >= g_vs0) && (line < g_vs0 + 16);
    exp_de = (line < g_de_lines) && (h < g_hd);
    exp_ra = (line < g_nonadj) ? 5'(line % 8) : 5'd0;
    exp_ma = 14'((g_base + (line / 8) * g_hd + h) % 16384);
    if (HSYNC !== exp_hs) err_hs++;
    if (VSYNC !== exp_vs) err_vs++;
    if (DE !== exp_de)    err_de++;
    if (RA !== exp_ra)    err_ra++;
    if (MA !== exp_ma)    err_ma++;
    if (line == 0 && h == 0) ma_l0 = MA;
    if (line == 8 && h == 0) ma_l8 = MA;
    cur_k++;
  endtask

  task automatic run_to(input int target);
    while (cur_k < target) clk_step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic end_segment(input string name);
    check({name, " hsync bad CEs"}, err_hs, 0);
    check({name, " vsync bad CEs"}, err_vs, 0);
    check({name, " de bad CEs"},    err_de, 0);
    check({name, " ra bad CEs"},    err_ra, 0);
    check({name, " ma bad CEs"},    err_ma, 0);
  endtask

  initial begin
    RESET = 1'b1; CE_1M = 1'b0; WE = 1'b0; RE = 1'b0; A = 1'b0; D = 8'h00;
    repeat (2) @(negedge CLK);
    check("reset MA", MA, 14'h3000);
    check("reset RA", RA, 5'd0);
    check("reset HSYNC", HSYNC, 1'b0);
    check("reset VSYNC", VSYNC, 1'b0);
    check("reset DE", DE, 1'b0);
    check("reset Q", Q, 8'hFF);
    RESET = 1'b0;
    CE_1M = 1'b1;

    // Frame 1: defaults, 312 lines.
    set_geom(14'h3000, 40, 14, 312, 240, 200);
    run_to(312 * 64);
    end_segment("f1 defaults");
    check("f1 MA line8 hcc0", ma_l8, 14'h3028);

    // Frame 2: HSW=0, written while the frame's first CEs run.
    set_geom(14'h3000, 40, 0, 312, 240, 200);
    clk_step(1'b1, 1'b0, 8'd3, 1'b0);
    clk_step(1'b1, 1'b1, 8'h80, 1'b0);
    run_to(312 * 64);
    end_segment("f2 hsw0");

    // Frame 3: HSW restored, R5=3, start address rewritten mid-frame, readbacks.
    set_geom(14'h3000, 40, 14, 312, 240, 200);
    clk_step(1'b1, 1'b0, 8'd3, 1'b0);
    clk_step(1'b1, 1'b1, 8'h8E, 1'b0);
    clk_step(1'b1, 1'b0, 8'd5, 1'b0);
    clk_step(1'b1, 1'b1, 8'd3, 1'b0);
    run_to(100 * 64);
    clk_step(1'b1, 1'b0, 8'd12, 1'b0);
    clk_step(1'b1, 1'b1, 8'h2A, 1'b0);
    clk_step(1'b0, 1'b1, 8'h00, 1'b1);
    check("read R12", Q, EXP_R12);
    clk_step(1'b1, 1'b1, 8'h10, 1'b0);
    clk_step(1'b1, 1'b0, 8'd13, 1'b0);
    clk_step(1'b1, 1'b1, 8'h20, 1'b0);
    run_to(250 * 64);
    clk_step(1'b1, 1'b0, 8'd31, 1'b0);
    clk_step(1'b0, 1'b1, 8'h00, 1'b1);
    check("read status line250", Q, EXP_ST);
    run_to(315 * 64);
    end_segment("f3 adjust");

    // Frame 4: base 0x1020, stride 80, 16-line frame, next base 0x3FF0.
    set_geom(14'h1020, 80, 14, 16, -1, 16);
    clk_step(1'b1, 1'b0, 8'd1, 1'b0);
    clk_step(1'b1, 1'b1, 8'd80, 1'b0);
    clk_step(1'b1, 1'b0, 8'd4, 1'b0);
    clk_step(1'b1, 1'b1, 8'd1, 1'b0);
    clk_step(1'b1, 1'b0, 8'd5, 1'b0);
    clk_step(1'b1, 1'b1, 8'd0, 1'b0);
    clk_step(1'b1, 1'b0, 8'd12, 1'b0);
    clk_step(1'b1, 1'b1, 8'h3F, 1'b0);
    clk_step(1'b1, 1'b0, 8'd13, 1'b0);
    clk_step(1'b1, 1'b1, 8'hF0, 1'b0);
    run_to(16 * 64);
    end_segment("f4 stride80");
    check("f4 MA line0 hcc0", ma_l0, 14'h1020);
    check("f4 MA line8 hcc0", ma_l8, 14'h1070);

    // Frame 5: 14-bit wrap of the row base; reset lands while HSYNC is high.
    set_geom(14'h3FF0, 80, 14, 16, -1, 16);
    run_to(9 * 64 + 50);
    end_segment("f5 wrap");
    check("f5 MA line8 hcc0", ma_l8, 14'h0040);
    check("f5 HSYNC before reset", HSYNC, 1'b1);

    RESET = 1'b1;
    @(negedge CLK);
    check("midframe reset MA", MA, 14'h3000);
    check("midframe reset HSYNC", HSYNC, 1'b0);
    check("midframe reset DE", DE, 1'b0);
    RESET = 1'b0;

    // Restarted frame uses the restored defaults.
    set_geom(14'h3000, 40, 14, 312, 240, 200);
    run_to(9 * 64);
    end_segment("post reset");
    check("post reset MA line8 hcc0", ma_l8, 14'h3028);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
